// File: rtl/uc_multiciclo.sv
// -----------------------------------------------------------------------------
// uc_multiciclo
// Multicycle control unit for the RV64 datapath. A two-process FSM walks each
// instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB) and drives
// the datapath write enables, mux selects and the 2-bit aluop for ALUControl.
// Unsupported opcodes park the FSM in TRAP until reset.
//
// Parameters
//   MEM_LATENCY  extra wait cycles per instruction fetch and per data access (0..15)
//   COUNT_WIDTH  width of the retired-instruction counter
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   run        in   1 = fetch new instructions, 0 = idle in FETCH
//   opcode     in   opcode field from the IR
//   flag       in   ULA zero/equal flag
//   weIR       out  IR load enable
//   wePC       out  PC load enable
//   weReg      out  register-file write enable
//   weMem      out  data-memory write enable
//   sinalMux1  out  ULA operand B: 0 = doutB, 1 = imm
//   sinalMux2  out  write-back source: 00 mem, 01 ULA, 10 PC+4, 11 PC+imm
//   sinalMux4  out  adder base: 0 = doutA, 1 = PC
//   pc_src     out  next PC: 0 = PC+4, 1 = PC+imm
//   aluop      out  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//   state      out  current state encoding
//   illegal    out  high while trapped on an unsupported opcode
//   instret    out  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module uc_multiciclo #(
    parameter int unsigned MEM_LATENCY = 0,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [6:0]             opcode,
    input  logic                   flag,
    output logic                   weIR,
    output logic                   wePC,
    output logic                   weReg,
    output logic                   weMem,
    output logic                   sinalMux1,
    output logic [1:0]             sinalMux2,
    output logic                   sinalMux4,
    output logic                   pc_src,
    output logic [1:0]             aluop,
    output logic [2:0]             state,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StTrap    = 3'd5
    } state_e;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpAddi = 7'b0010011;
    localparam logic [6:0] OpLd   = 7'b0000011;
    localparam logic [6:0] OpSd   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    localparam logic [3:0] WaitLast = 4'(MEM_LATENCY);

    state_e                 state_q, state_d;
    logic [3:0]             wait_q, wait_d;
    logic [COUNT_WIDTH-1:0] instret_q, instret_d;

    // Raw enables before reset gating.
    logic we_ir, we_pc, we_reg, we_mem;
    logic legal_op;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        legal_op = (opcode == OpR)  || (opcode == OpAddi) || (opcode == OpLd) ||
                   (opcode == OpSd) || (opcode == OpBeq)  || (opcode == OpJal);
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        we_ir     = 1'b0;
        we_pc     = 1'b0;
        we_reg    = 1'b0;
        we_mem    = 1'b0;
        sinalMux1 = 1'b0;
        sinalMux2 = 2'b00;
        sinalMux4 = 1'b0;
        pc_src    = 1'b0;
        aluop     = 2'b00;

        case (state_q)
            StFetch: begin
                if (run) begin
                    if (wait_q == WaitLast) begin
                        we_ir   = 1'b1;
                        wait_d  = '0;
                        state_d = StDecode;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end else begin
                    wait_d = '0;
                end
            end

            StDecode: begin
                state_d = legal_op ? StExecute : StTrap;
            end

            StExecute: begin
                case (opcode)
                    OpR: begin
                        aluop   = 2'b10;
                        state_d = StWb;
                    end
                    OpAddi: begin
                        aluop     = 2'b11;
                        sinalMux1 = 1'b1;
                        state_d   = StWb;
                    end
                    OpLd, OpSd: begin
                        sinalMux1 = 1'b1;
                        state_d   = StMem;
                    end
                    OpBeq: begin
                        aluop   = 2'b01;
                        we_pc   = 1'b1;
                        pc_src  = flag;
                        state_d = StFetch;
                    end
                    default: begin
                        // jal does its work in WB
                        state_d = StWb;
                    end
                endcase
            end

            StMem: begin
                sinalMux1 = 1'b1;
                if (wait_q == WaitLast) begin
                    wait_d = '0;
                    if (opcode == OpSd) begin
                        we_mem  = 1'b1;
                        we_pc   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end

            StWb: begin
                we_reg  = 1'b1;
                we_pc   = 1'b1;
                state_d = StFetch;
                case (opcode)
                    OpLd:    sinalMux2 = 2'b00;
                    OpJal: begin
                        sinalMux2 = 2'b10;
                        sinalMux4 = 1'b1;
                        pc_src    = 1'b1;
                    end
                    default: sinalMux2 = 2'b01;
                endcase
            end

            StTrap: begin
                state_d = StTrap;
            end

            default: begin
                state_d = StFetch;
                wait_d  = '0;
            end
        endcase
    end

    // A reset cycle must not commit anything, e.g. a pending store in MEM.
    assign weIR    = we_ir  & ~reset;
    assign wePC    = we_pc  & ~reset;
    assign weReg   = we_reg & ~reset;
    assign weMem   = we_mem & ~reset;

    assign instret_d = wePC ? instret_q + COUNT_WIDTH'(1) : instret_q;

    assign state   = state_q;
    assign illegal = (state_q == StTrap);
    assign instret = instret_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: four instances with different latencies run side by
// side. Each keeps a per-instruction schedule of expected outputs built from
// the opcode class and latency, compared every cycle, plus literal checks.
module tb_uc_multiciclo;

    localparam int NI = 4;
    localparam int unsigned LATS [NI] = '{0, 1, 2, 3};
    localparam int unsigned CWS  [NI] = '{2, 32, 32, 32};

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpAddi = 7'b0010011;
    localparam logic [6:0] OpLd   = 7'b0000011;
    localparam logic [6:0] OpSd   = 7'b0100011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] LEGAL [6] = '{OpR, OpAddi, OpLd, OpSd, OpBeq, OpJal};

    // {state[2:0], weIR, wePC, weReg, weMem, mux1, mux2[1:0], mux4, pc_src, aluop[1:0], illegal}
    typedef struct packed {
        logic [14:0] v;
        logic        pcflag;
        logic        trap_after;
    } exp_t;

    logic clock;
    logic g_reset;
    int   g_run_mode;
    bit   g_allow_ill;
    int   g_force_op [NI];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 0 R, 1 addi, 2 ld, 3 sd, 4 beq, 5 jal, 6 illegal
    function automatic int classify(input logic [6:0] op);
        for (int i = 0; i < 6; i++) if (op == LEGAL[i]) return i;
        return 6;
    endfunction

    function automatic logic [14:0] mk(input int st, input bit wi, input bit wp, input bit wr,
                                       input bit wm, input bit m1, input int m2, input bit m4,
                                       input bit pc, input int alu, input bit il);
        return {3'(st), wi, wp, wr, wm, m1, 2'(m2), m4, pc, 2'(alu), il};
    endfunction

    function automatic logic [6:0] pick_op(input int idx);
        if (g_force_op[idx] >= 0) return 7'(g_force_op[idx]);
        if (g_allow_ill && $urandom_range(0, 31) == 0) return 7'($urandom_range(0, 127));
        return LEGAL[$urandom_range(0, 5)];
    endfunction

    function automatic logic pick_run();
        if (g_run_mode == 0) return 1'b0;
        if (g_run_mode == 1) return 1'b1;
        return ($urandom_range(0, 9) != 0);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L  = LATS[g];
        localparam int unsigned CW = CWS[g];

        logic          run, flag;
        logic [6:0]    opcode;
        logic          weIR, wePC, weReg, weMem, sinalMux1, sinalMux4, pc_src, illegal;
        logic [1:0]    sinalMux2, aluop;
        logic [2:0]    state;
        logic [CW-1:0] instret;
        logic [14:0]   obs;
        logic [31:0]   irv;

        uc_multiciclo #(
            .MEM_LATENCY(L),
            .COUNT_WIDTH(CW)
        ) dut (
            .clock    (clock),
            .reset    (g_reset),
            .run      (run),
            .opcode   (opcode),
            .flag     (flag),
            .weIR     (weIR),
            .wePC     (wePC),
            .weReg    (weReg),
            .weMem    (weMem),
            .sinalMux1(sinalMux1),
            .sinalMux2(sinalMux2),
            .sinalMux4(sinalMux4),
            .pc_src   (pc_src),
            .aluop    (aluop),
            .state    (state),
            .illegal  (illegal),
            .instret  (instret)
        );

        assign obs = {state, weIR, wePC, weReg, weMem, sinalMux1, sinalMux2, sinalMux4, pc_src,
                      aluop, illegal};
        assign irv = 32'(instret);

        exp_t        q[$];
        int unsigned mfetch = 0;
        int unsigned icount = 0;
        bit          trapped = 0;
        logic [14:0] ev;
        exp_t        e;

        // Schedule of every post-fetch cycle of one instruction.
        task automatic build(input logic [6:0] op);
            int  c;
            bit  st;
            exp_t x;
            c = classify(op);
            x = '{v: mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), pcflag: 1'b0, trap_after: (c == 6)};
            q.push_back(x);
            if (c == 6) return;
            x.trap_after = 1'b0;
            case (c)
                0: x.v = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
                1: x.v = mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
                2, 3: x.v = mk(2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
                4: begin
                    x.v = mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
                    x.pcflag = 1'b1;
                end
                default: x.v = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            q.push_back(x);
            x.pcflag = 1'b0;
            if (c == 4) return;
            if (c == 2 || c == 3) begin
                for (int i = 0; i <= int'(L); i++) begin
                    st = (c == 3) && (i == int'(L));
                    x.v = mk(3, 0, st, 0, st, 1, 0, 0, 0, 0, 0);
                    q.push_back(x);
                end
                if (c == 3) return;
            end
            case (c)
                2: x.v = mk(4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
                5: x.v = mk(4, 0, 1, 1, 0, 0, 2, 1, 1, 0, 0);
                default: x.v = mk(4, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
            endcase
            q.push_back(x);
        endtask

        always @(negedge clock) begin
            // opcode may only change while the instruction is still being fetched
            if (q.size() == 0 && !trapped) opcode = pick_op(g);
            flag = 1'($urandom_range(0, 1));
            run  = pick_run();
            #1;
            if (trapped) ev = mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
            else if (q.size() != 0) begin
                ev = q[0].v;
                if (q[0].pcflag) ev[3] = flag;
            end else ev = mk(0, run && (mfetch == L), 0, 0, 0, 0, 0, 0, 0, 0, 0);
            if (g_reset) ev[11:8] = 4'b0000;

            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL outputs inst%0d t=%0t: got %b expected %b", g, $time, obs, ev);
            end
            n_cmp++;
            if (irv !== icount) begin
                n_err++;
                $display("FAIL instret inst%0d t=%0t: got %0d expected %0d", g, $time, irv,
                         icount);
            end

            if (g_reset) begin
                q.delete();
                trapped = 0;
                mfetch  = 0;
                icount  = 0;
            end else begin
                if (ev[10]) icount = 32'((64'(icount) + 64'd1) % (64'd1 << CW));
                if (trapped) begin
                end else if (q.size() != 0) begin
                    e = q.pop_front();
                    if (e.trap_after) trapped = 1;
                end else if (run) begin
                    if (mfetch == L) begin
                        mfetch = 0;
                        build(opcode);
                    end else mfetch++;
                end else mfetch = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int first [NI];
        int cnt_a, cnt_b;

        g_reset     = 1'b1;
        g_run_mode  = 1;
        g_allow_ill = 1'b0;
        g_force_op  = '{int'(OpR), int'(OpSd), int'(OpLd), int'(OpBeq)};
        repeat (3) cyc();
        #1;
        check("reset_state", int'(g_dut[0].state), 0);
        check("reset_instret", int'(g_dut[3].irv), 0);
        check("reset_illegal", int'(g_dut[2].illegal), 0);
        check("reset_weIR", int'(g_dut[1].weIR), 0);

        // Directed first instruction per instance; release reset, this cycle is k=0.
        g_reset = 1'b0;
        first = '{-1, -1, -1, -1};
        for (int k = 1; k <= 24; k++) begin
            cyc();
            #1;
            if (first[0] < 0 && g_dut[0].irv != 0) first[0] = k;
            if (first[1] < 0 && g_dut[1].irv != 0) first[1] = k;
            if (first[2] < 0 && g_dut[2].irv != 0) first[2] = k;
            if (first[3] < 0 && g_dut[3].irv != 0) first[3] = k;
            if (k == 20) check("wrap_5_retired_cw2", int'(g_dut[0].irv), 1);
        end
        check("latency_R_L0", first[0], 4);
        check("latency_sd_L1", first[1], 6);
        check("latency_ld_L2", first[2], 9);
        check("latency_beq_L3", first[3], 6);

        // Idle: run=0 holds FETCH.
        g_reset    = 1'b1;
        g_run_mode = 0;
        cyc();
        g_reset = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            #1;
            if (g_dut[0].weIR || g_dut[2].weIR) cnt_a++;
            if (g_dut[3].state == 3'd0) cnt_b++;
        end
        check("idle_weIR_pulses", cnt_a, 0);
        check("idle_fetch_cycles", cnt_b, 10);

        // Random traffic with occasional illegal opcodes and resets.
        g_force_op  = '{-1, -1, -1, -1};
        g_allow_ill = 1'b1;
        g_run_mode  = 2;
        repeat (3000) begin
            cyc();
            g_reset = ($urandom_range(0, 149) == 0);
        end

        // Illegal opcode traps until reset.
        g_reset     = 1'b1;
        g_allow_ill = 1'b0;
        g_run_mode  = 1;
        g_force_op  = '{127, 127, 127, 127};
        cyc();
        g_reset = 1'b0;
        repeat (4) cyc();
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            #1;
            if (g_dut[0].weIR || g_dut[0].wePC || g_dut[0].weReg || g_dut[0].weMem) cnt_a++;
            if (g_dut[0].state == 3'd5 && g_dut[0].illegal) cnt_b++;
        end
        check("trap_enables", cnt_a, 0);
        check("trap_cycles", cnt_b, 20);
        g_reset = 1'b1;
        cyc();
        #1;
        check("trap_reset_state", int'(g_dut[0].state), 0);
        check("trap_reset_illegal", int'(g_dut[0].illegal), 0);

        // Reset in the first MEM cycle of sd (L=3) must suppress the store.
        g_force_op = '{int'(OpSd), int'(OpSd), int'(OpSd), int'(OpSd)};
        g_reset    = 1'b0;
        cnt_a = 0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (k == 6) begin
                check("sd_in_mem_L3", int'(g_dut[3].state), 3);
                g_reset = 1'b1;
            end
            if (k == 11) g_reset = 1'b0;
            #1;
            if (g_dut[3].weMem) cnt_a++;
        end
        check("sd_reset_weMem", cnt_a, 0);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
